// File: rtl/sram_spi_pkg.sv
// Shared constants, controller states and byte-strobe helpers for the serial SRAM controller.
package sram_spi_pkg;
  localparam logic [7:0] SPI_READ_CMD  = 8'h03;
  localparam logic [7:0] SPI_WRITE_CMD = 8'h02;

  typedef enum logic [2:0] {ST_GAP, ST_IDLE, ST_CMD, ST_ADDR, ST_RDATA, ST_WDATA} ctrl_state_e;

  typedef struct packed {
    logic       ok;
    logic [1:0] off;
    logic [2:0] n;
  } be_dec_t;

  function automatic be_dec_t be_decode(input logic [3:0] be);
    be_dec_t r;
    r = '{ok: 1'b1, off: 2'd0, n: 3'd1};
    case (be)
      4'b0001: r.off = 2'd0;
      4'b0010: r.off = 2'd1;
      4'b0100: r.off = 2'd2;
      4'b1000: r.off = 2'd3;
      4'b0011: r.n = 3'd2;
      4'b1100: begin r.off = 2'd2; r.n = 3'd2; end
      4'b1111: r.n = 3'd4;
      default: r.ok = 1'b0;
    endcase
    return r;
  endfunction

  // Left-justify the strobed bytes, lowest address first, for MSB-first shifting.
  function automatic logic [31:0] pack_wdata(input logic [31:0] w, input be_dec_t d);
    logic [31:0] t;
    t = '0;
    for (int k = 0; k < 4; k++)
      if (k < int'(d.n) && (k + int'(d.off)) < 4)
        t[31-8*k -: 8] = w[8*(k+int'(d.off)) +: 8];
    return t;
  endfunction

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction
endpackage

// File: rtl/sram_spi_phy.sv
// SPI mode-0 bit engine: free-running sclk divider, MSB-first shift-out on falls, shift-in on rises.
module sram_spi_phy #(
  parameter int HALF_PER = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  nbits,
  input  logic [31:0] din,
  output logic        done,
  output logic        rise,
  output logic [31:0] rx_word,
  output logic        sclk,
  output logic        si,
  input  logic        so
);
  localparam int DW = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;

  logic [DW-1:0] div_cnt;
  logic          tick, fall, busy;
  logic [5:0]    bit_cnt;
  logic [31:0]   sh;
  logic [30:0]   rx;

  assign tick    = (div_cnt == DW'(HALF_PER - 1));
  assign rise    = tick && !sclk;
  assign fall    = tick && sclk;
  assign done    = busy && rise && (bit_cnt == 6'd1);
  // The final bit is sampled on the same edge that reports done.
  assign rx_word = {rx, so};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      sclk    <= 1'b0;
      si      <= 1'b0;
      busy    <= 1'b0;
      bit_cnt <= '0;
      sh      <= '0;
      rx      <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) sclk <= ~sclk;
      if (start) begin
        busy    <= 1'b1;
        bit_cnt <= nbits;
        sh      <= din;
      end else if (busy && rise) begin
        rx      <= {rx[29:0], so};
        bit_cnt <= bit_cnt - 6'd1;
        if (bit_cnt == 6'd1) busy <= 1'b0;
      end else if (fall) begin
        si <= busy ? sh[31] : 1'b0;
        if (busy) sh <= {sh[30:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/sram_spi_ctrl.sv
// Two-port (ifetch/data) arbiter and transaction sequencer for a serial SRAM behind sram_spi_phy.
module sram_spi_ctrl
  import sram_spi_pkg::*;
#(
  parameter int HALF_PER = 1,
  parameter int GAP_SCLK = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_valid,
  input  logic [23:0] i_addr,
  output logic        i_ready,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic        d_we,
  input  logic [23:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        sclk,
  output logic        ce,
  output logic        si,
  input  logic        so
);
  localparam int GW = $clog2(GAP_SCLK + 1);

  ctrl_state_e   state;
  logic [GW-1:0] gap_cnt;
  logic          last_d, src_d, we_q, gnt_i, gnt_d, d_ok;
  logic [23:0]   addr_q;
  logic [31:0]   tx_q;
  logic [2:0]    n_q;
  logic          phy_start, phy_done, phy_rise;
  logic [5:0]    phy_nbits;
  logic [31:0]   phy_din, phy_rx;
  be_dec_t       dec;

  assign dec  = be_decode(d_be);
  assign d_ok = !d_we || dec.ok;

  // Grants land on an sclk rise so the first bit is driven on the following fall.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (state == ST_IDLE && phy_rise && !i_ready && !d_ready) begin
      if (i_valid && d_valid) begin
        gnt_i = last_d;
        gnt_d = !last_d;
      end else begin
        gnt_i = i_valid;
        gnt_d = d_valid;
      end
    end
  end

  assign phy_start = gnt_i || (gnt_d && d_ok) ||
                     (phy_done && (state == ST_CMD || state == ST_ADDR));

  always_comb begin
    phy_nbits = 6'd0;
    phy_din   = '0;
    case (state)
      ST_IDLE: begin
        phy_nbits = 6'd8;
        phy_din   = {(gnt_d && d_we) ? SPI_WRITE_CMD : SPI_READ_CMD, 24'h0};
      end
      ST_CMD: begin
        phy_nbits = 6'd24;
        phy_din   = {addr_q, 8'h0};
      end
      ST_ADDR: begin
        phy_nbits = we_q ? {n_q, 3'b000} : 6'd32;
        phy_din   = we_q ? tx_q : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_GAP;
      gap_cnt  <= GW'(GAP_SCLK);
      last_d   <= 1'b1;
      src_d    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      tx_q     <= '0;
      n_q      <= '0;
      ce       <= 1'b0;
      i_ready  <= 1'b0;
      i_rvalid <= 1'b0;
      i_rdata  <= '0;
      d_ready  <= 1'b0;
      d_rvalid <= 1'b0;
      d_rdata  <= '0;
      d_err    <= 1'b0;
    end else begin
      i_ready  <= 1'b0;
      i_rvalid <= 1'b0;
      d_ready  <= 1'b0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      case (state)
        ST_GAP:
          if (phy_rise) begin
            if (gap_cnt == GW'(1)) state <= ST_IDLE;
            else gap_cnt <= gap_cnt - 1'b1;
          end
        ST_IDLE:
          if (gnt_i) begin
            i_ready <= 1'b1;
            last_d  <= 1'b0;
            src_d   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= i_addr;
            ce      <= 1'b1;
            state   <= ST_CMD;
          end else if (gnt_d) begin
            d_ready <= 1'b1;
            last_d  <= 1'b1;
            if (!d_ok) d_err <= 1'b1;
            else begin
              src_d  <= 1'b1;
              we_q   <= d_we;
              addr_q <= d_we ? d_addr + 24'(dec.off) : d_addr;
              tx_q   <= pack_wdata(d_wdata, dec);
              n_q    <= dec.n;
              ce     <= 1'b1;
              state  <= ST_CMD;
            end
          end
        ST_CMD:
          if (phy_done) state <= ST_ADDR;
        ST_ADDR:
          if (phy_done) state <= we_q ? ST_WDATA : ST_RDATA;
        ST_RDATA:
          if (phy_done) begin
            ce      <= 1'b0;
            state   <= ST_GAP;
            gap_cnt <= GW'(GAP_SCLK);
            if (src_d) begin
              d_rvalid <= 1'b1;
              d_rdata  <= byte_swap(phy_rx);
            end else begin
              i_rvalid <= 1'b1;
              i_rdata  <= byte_swap(phy_rx);
            end
          end
        ST_WDATA:
          if (phy_done) begin
            ce       <= 1'b0;
            state    <= ST_GAP;
            gap_cnt  <= GW'(GAP_SCLK);
            d_rvalid <= 1'b1;
            d_rdata  <= '0;
          end
        default: state <= ST_GAP;
      endcase
    end
  end

  sram_spi_phy #(.HALF_PER(HALF_PER)) u_phy (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (phy_start),
    .nbits   (phy_nbits),
    .din     (phy_din),
    .done    (phy_done),
    .rise    (phy_rise),
    .rx_word (phy_rx),
    .sclk    (sclk),
    .si      (si),
    .so      (so)
  );
endmodule
